// File: rtl/univ_shift_pkg.sv
// ----------------------------------------------------------------------------
// univ_shift_pkg
//   Shared definitions for the universal shift register and its shift counter:
//   operation-select encodings, counter state encoding and a small helper that
//   classifies a mode as a shift.
// ----------------------------------------------------------------------------
package univ_shift_pkg;

   // Operation select carried on the 2-bit mode port.
   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   // Saturating shift counter states.
   typedef enum logic {
      ST_COUNTING  = 1'b0,
      ST_EXHAUSTED = 1'b1
   } cnt_state_e;

   // True for either shift direction; both directions advance the counter.
   function automatic logic is_shift(input mode_e m);
      return (m == MODE_SHR) || (m == MODE_SHL);
   endfunction

endpackage

// File: rtl/shift_counter.sv
// ----------------------------------------------------------------------------
// shift_counter
//   Counts shift operations since the last LOAD or reset, saturating at WIDTH.
//   Emits a registered one-cycle done pulse on the edge the count reaches WIDTH.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_mode   : operation select (HOLD/SHR/SHL/LOAD)
//   o_cnt    : shifts since last LOAD/reset, saturating at WIDTH
//   o_done   : one-cycle pulse when o_cnt becomes WIDTH
// ----------------------------------------------------------------------------
module shift_counter
   import univ_shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [1:0]                   i_mode,
   output logic [$clog2(WIDTH+1)-1:0]   o_cnt,
   output logic                         o_done
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LP_LAST = CW'(WIDTH - 1);

   cnt_state_e       r_state;
   cnt_state_e       w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             r_done;
   logic             w_done_nxt;
   mode_e            w_mode;

   assign w_mode = mode_e'(i_mode);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_COUNTING;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      if (w_mode == MODE_LOAD) begin
         w_state_nxt = ST_COUNTING;
         w_cnt_nxt   = '0;
      end else if (is_shift(w_mode)) begin
         case (r_state)
            ST_COUNTING: begin
               w_cnt_nxt = r_cnt + CW'(1);
               if (r_cnt == LP_LAST) begin
                  w_state_nxt = ST_EXHAUSTED;
                  w_done_nxt  = 1'b1;
               end
            end
            default: begin
               // Exhausted: count frozen at WIDTH until LOAD or reset.
            end
         endcase
      end
   end

   assign o_cnt  = r_cnt;
   assign o_done = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// ----------------------------------------------------------------------------
// univ_shift_reg
//   Universal shift register: hold, shift right, shift left, parallel load,
//   with optional rotate, serial outputs and a saturating shift counter.
//
// Ports
//   c        : clock, all state updates on rising edge
//   rn       : asynchronous active-low reset
//   mode     : 00 HOLD, 01 SHR, 10 SHL, 11 LOAD
//   d        : parallel load data
//   sin_msb  : serial input into Q[WIDTH-1] on SHR
//   sin_lsb  : serial input into Q[0] on SHL
//   rot      : rotate; shifted-out bit re-enters, serial inputs ignored
//   Q        : registered contents
//   sout_lsb : Q[0]
//   sout_msb : Q[WIDTH-1]
//   cnt      : shifts since last LOAD/reset, saturating at WIDTH
//   done     : one-cycle pulse when cnt reaches WIDTH
// ----------------------------------------------------------------------------
module univ_shift_reg
   import univ_shift_pkg::*;
#(
   parameter int unsigned          WIDTH       = 8,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input  logic                         c,
   input  logic                         rn,
   input  logic [1:0]                   mode,
   input  logic [WIDTH-1:0]             d,
   input  logic                         sin_msb,
   input  logic                         sin_lsb,
   input  logic                         rot,
   output logic [WIDTH-1:0]             Q,
   output logic                         sout_lsb,
   output logic                         sout_msb,
   output logic [$clog2(WIDTH+1)-1:0]   cnt,
   output logic                         done
);

   mode_e            w_mode;
   logic [WIDTH-1:0] w_q;

   assign w_mode = mode_e'(mode);

   // One flip-flop per bit; each bit picks its own neighbour for the shift.
   // End bits take the serial input or, when rotating, the opposite end bit,
   // which also covers WIDTH=1 (the bit is its own neighbour).
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic r_bit;
      logic w_shr_in;
      logic w_shl_in;
      logic w_nxt;

      if (gi == WIDTH - 1) begin : g_msb
         assign w_shr_in = rot ? w_q[0] : sin_msb;
      end else begin : g_not_msb
         assign w_shr_in = w_q[gi+1];
      end

      if (gi == 0) begin : g_lsb
         assign w_shl_in = rot ? w_q[WIDTH-1] : sin_lsb;
      end else begin : g_not_lsb
         assign w_shl_in = w_q[gi-1];
      end

      always_comb begin
         w_nxt = r_bit;
         case (w_mode)
            MODE_SHR:  w_nxt = w_shr_in;
            MODE_SHL:  w_nxt = w_shl_in;
            MODE_LOAD: w_nxt = d[gi];
            default:   w_nxt = r_bit;
         endcase
      end

      always_ff @(posedge c or negedge rn) begin
         if (!rn) begin
            r_bit <= RESET_VALUE[gi];
         end else begin
            r_bit <= w_nxt;
         end
      end

      assign w_q[gi] = r_bit;
   end

   shift_counter #(
      .WIDTH (WIDTH)
   ) u_shift_counter (
      .i_clk   (c),
      .i_rst_n (rn),
      .i_mode  (mode),
      .o_cnt   (cnt),
      .o_done  (done)
   );

   assign Q        = w_q;
   assign sout_lsb = w_q[0];
   assign sout_msb = w_q[WIDTH-1];

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range 1..64).
REQ-002 SHALL have parameter RESET_VALUE, default 0, meaning the WIDTH-bit value loaded into Q on reset.
REQ-003 SHALL have port c, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rn, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have port mode, input, 2, meaning operation select: 00 HOLD, 01 SHR, 10 SHL, 11 LOAD.
REQ-006 SHALL have port d, input, WIDTH, meaning parallel load data.
REQ-007 SHALL have port sin_msb, input, 1, meaning the serial bit entering Q[WIDTH-1] on SHR.
REQ-008 SHALL have port sin_lsb, input, 1, meaning the serial bit entering Q[0] on SHL.
REQ-009 SHALL have port rot, input, 1, meaning rotate: when 1, the bit shifted out re-enters and the serial inputs are ignored.
REQ-010 SHALL have port Q, output, WIDTH, meaning registered contents.
REQ-011 SHALL have port sout_lsb, output, 1, meaning combinational Q[0].
REQ-012 SHALL have port sout_msb, output, 1, meaning combinational Q[WIDTH-1].
REQ-013 SHALL have port cnt, output, clog2(WIDTH+1), meaning the number of shifts since the last LOAD or reset, saturating at WIDTH.
REQ-014 SHALL have port done, output, 1, meaning a registered one-cycle pulse when cnt reaches WIDTH.

Function
REQ-015 HOLD SHALL leave Q and cnt unchanged and drive done to 0.
REQ-016 SHR SHALL set Q <= {rot ? Q[0] : sin_msb, Q[WIDTH-1:1]}; for WIDTH=1, Q <= rot ? Q : sin_msb.
REQ-017 SHL SHALL set Q <= {Q[WIDTH-2:0], rot ? Q[WIDTH-1] : sin_lsb}; for WIDTH=1, Q <= rot ? Q : sin_lsb.
REQ-018 LOAD SHALL set Q <= d, cnt <= 0 and done <= 0.
REQ-019 Q SHALL have a latency of one edge: a mode/data change is visible on Q immediately after the next rising edge of c and never earlier.
REQ-020 The counter SHALL have two states: COUNTING (cnt<WIDTH) and EXHAUSTED (cnt==WIDTH).
REQ-021 In COUNTING, each SHR or SHL edge SHALL increment cnt by 1; mixed directions all count.
REQ-022 On the edge where cnt goes WIDTH-1 -> WIDTH, done SHALL be 1 for exactly that cycle.
REQ-023 In EXHAUSTED, shifts SHALL still update Q while cnt stays WIDTH and done stays 0.
REQ-024 EXHAUSTED SHALL return to COUNTING only via LOAD or reset.
REQ-025 Inputs SHALL be sampled only at the rising edge; changes while c is high or low SHALL NOT alter Q.

Reset
REQ-026 rn=0 SHALL immediately, without a clock edge, force Q=RESET_VALUE, cnt=0 and done=0; sout_lsb and sout_msb follow Q.
REQ-027 While rn=0, clock edges SHALL be ignored.
REQ-028 The first rising edge after rn rises SHALL execute mode normally.
REQ-029 Reset asserted mid-shift-sequence SHALL discard the count; no done pulse SHALL be emitted.

Structure
REQ-030 Mode encodings (HOLD, SHR, SHL, LOAD) SHALL be constants in shared package univ_shift_pkg.
REQ-031 The cnt/done saturating counter SHALL be one sub-module, shift_counter, parametrised by WIDTH.
REQ-032 The data path SHALL be built from WIDTH async-reset flip-flop bits with per-bit next-value muxing.

Verification
REQ-033 WIDTH=8: LOAD 8'hA5, then rn=0 between edges -> Q=8'h00, cnt=0 and done=0 before any edge.
REQ-034 WIDTH=8: LOAD 8'hB4, then SHR with sin_msb=1, rot=0 -> Q=8'hDA and sout_lsb=0.
REQ-035 WIDTH=8: LOAD 8'h81, then SHL with rot=1, sin_lsb=0 -> Q=8'h03 and sout_msb=0.
REQ-036 WIDTH=8: LOAD, then 8 SHR edges -> cnt=8 and done=1 only after the 8th edge; 9th SHR -> cnt=8 and done=0.
REQ-037 WIDTH=8: after 5 shifts, 3 HOLD edges -> Q unchanged, cnt=5, done=0; then LOAD 8'h3C -> Q=8'h3C, cnt=0.
REQ-038 WIDTH=1: LOAD 0, then SHL with sin_lsb=1 -> Q=1, cnt=1, done pulses for one cycle.
